crt_clock_divider: RTL and testbench



---
 rtl/crt_clock_divider.sv | 59 +++++
 tb/tb_crt_clock_divider.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/crt_clock_divider.sv
// Pixel-clock generator: divides Clock by floor(SystemClockFreq / CRTClockFreq)
// and drives PixelClock from a flop (high for floor(N/2) cycles of each N).
module crt_clock_divider #(
  parameter int FreqWidth = 10
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [FreqWidth-1:0] SystemClockFreq,
  input  logic [FreqWidth-1:0] CRTClockFreq,
  output logic                 PixelClock
);

  localparam int W = FreqWidth;

  logic [W:0]   rem;
  logic [W-1:0] ratio;
  logic [W-1:0] count;
  logic [W-1:0] next_count;
  logic [W-1:0] high_start;
  logic         ratio_ok;
  logic         pix_next;

  // Restoring long division, MSB first; a zero divisor yields all-ones and is
  // rejected by ratio_ok below rather than special-cased here.
  always_comb begin : divide
    rem   = '0;
    ratio = '0;
    for (int i = W - 1; i >= 0; i--) begin
      rem   = {rem[W-1:0], SystemClockFreq[i]};
      ratio = {ratio[W-2:0], 1'b0};
      if (rem >= {1'b0, CRTClockFreq}) begin
        rem      = rem - {1'b0, CRTClockFreq};
        ratio[0] = 1'b1;
      end
    end
  end

  assign ratio_ok = (CRTClockFreq != '0) && (ratio >= W'(2));

  always_comb begin : next_state
    high_start = ratio - (ratio >> 1);
    next_count = (count >= ratio - W'(1)) ? '0 : count + W'(1);
    pix_next   = (next_count >= high_start);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count      <= '0;
      PixelClock <= 1'b0;
    end else if (!ratio_ok) begin
      count      <= '0;
      PixelClock <= 1'b0;
    end else begin
      count      <= next_count;
      PixelClock <= pix_next;
    end
  end

endmodule

// File: tb/tb_crt_clock_divider.sv
// Bench for crt_clock_divider: reference model of the divided waveform plus
// directed literal sequences and randomized frequency/reset stimulus.
`timescale 1ns/100ps
module tb_crt_clock_divider;

  localparam int FW = 10;

  logic          Clock;
  logic          Reset;
  logic [FW-1:0] SystemClockFreq;
  logic [FW-1:0] CRTClockFreq;
  logic          PixelClock;

  int checks   = 0;
  int failures = 0;

  // Reference model: position within the current period and expected output
  int   m_pos;
  logic m_pix;

  crt_clock_divider #(.FreqWidth(FW)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .SystemClockFreq(SystemClockFreq),
    .CRTClockFreq   (CRTClockFreq),
    .PixelClock     (PixelClock)
  );

  initial Clock = 1'b1;
  always #4 Clock = ~Clock;

  function automatic int ratio_of(input int sys, input int crt);
    if (crt == 0) return 0;
    return sys / crt;
  endfunction

  always @(posedge Clock or posedge Reset) begin
    int n;
    if (Reset) begin
      m_pos = 0;
      m_pix = 1'b0;
    end else begin
      n = ratio_of(int'(SystemClockFreq), int'(CRTClockFreq));
      if (n < 2) begin
        m_pos = 0;
        m_pix = 1'b0;
      end else begin
        m_pos = (m_pos >= n - 1) ? 0 : m_pos + 1;
        m_pix = (m_pos >= n - n / 2);
      end
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if ($isunknown(act) || act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge Clock) begin
    #1;
    check("model_cmp", PixelClock, m_pix);
  end

  task automatic set_freq(input int sys, input int crt);
    SystemClockFreq = FW'(sys);
    CRTClockFreq    = FW'(crt);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    #2;
    Reset = 1'b0;
  endtask

  task automatic expect_seq(input string name, input logic [7:0] seq, input int len);
    for (int k = 0; k < len; k++) begin
      @(posedge Clock);
      #1;
      check(name, PixelClock, seq[k]);
    end
  endtask

  initial begin
    int highs;
    Reset = 1'b1;
    set_freq(100, 20);

    // Reset held 0..20 ns with an active clock
    #3;  check("reset_hold", PixelClock, 1'b0);
    #10; check("reset_hold", PixelClock, 1'b0);
    #7;  Reset = 1'b0;

    // N=5: 0,0,1,1,0 (seq bits are LSB-first)
    expect_seq("div5_first", 8'b00001100, 5);
    for (int p = 0; p < 20; p++) begin
      highs = 0;
      for (int k = 0; k < 5; k++) begin
        @(posedge Clock);
        #1;
        if (PixelClock === 1'b1) highs++;
        if (k == 4) check("div5_period_end", PixelClock, 1'b0);
      end
      check_int("div5_highs", highs, 2);
    end

    // N=4: 0,1,1,0 then repeating
    set_freq(100, 25);
    do_reset();
    expect_seq("div4_seq", 8'b01100110, 8);

    // Degenerate ratios keep the output low
    set_freq(100, 0);
    repeat (6) @(negedge Clock);
    check("degen_crt0", PixelClock, 1'b0);
    set_freq(100, 150);
    repeat (6) @(negedge Clock);
    check("degen_n0", PixelClock, 1'b0);
    set_freq(100, 100);
    repeat (6) @(negedge Clock);
    check("degen_n1", PixelClock, 1'b0);

    // N=10 to N=2 while count=8: wrap, then toggle 0,1,0,1
    set_freq(100, 10);
    do_reset();
    expect_seq("div10_lead", 8'b11110000, 8);
    set_freq(100, 50);
    expect_seq("shrink_wrap", 8'b00001010, 4);

    // Async reset while high, then restart 0,0,1,1,0
    set_freq(100, 20);
    do_reset();
    expect_seq("pre_async", 8'b00000100, 3);
    Reset = 1'b1;
    #1;
    check("async_low", PixelClock, 1'b0);
    @(negedge Clock);
    #2;
    Reset = 1'b0;
    expect_seq("post_async", 8'b00001100, 5);

    // Randomized frequencies and occasional async reset pulses
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clock);
      #2;
      if ($urandom_range(99) < 4) begin
        case ($urandom_range(3))
          0: set_freq($urandom_range(1023), $urandom_range(1023));
          1: set_freq($urandom_range(200, 20), $urandom_range(12, 0));
          2: set_freq($urandom_range(100, 2), $urandom_range(60, 1));
          default: set_freq(100, $urandom_range(55, 9));
        endcase
      end
      if ($urandom_range(199) == 0) begin
        Reset = 1'b1;
        #1;
        check("rand_async", PixelClock, 1'b0);
        Reset = 1'b0;
      end
    end

    @(negedge Clock);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
